// File: rtl/epp_bridge.sv
// EPP-mode parallel port slave: turns host address/data strobe cycles into
// single-cycle ip_wr/ip_rd pulses on the internal 8-bit register bus.
module epp_bridge #(
    parameter int          SYNC_STAGES = 2,
    parameter int          AUTO_INC    = 1,
    parameter int          TIMEOUT     = 255,
    parameter logic [7:0]  ERR_DATA    = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire  [7:0] Db_unsync,
    input  logic       Astb_unsync,
    input  logic       Dstb_unsync,
    input  logic       Wr_unsync,
    output logic       Wait,
    output logic [7:0] ip_addr,
    output logic [7:0] ip_do,
    output logic       ip_wr,
    output logic       ip_rd,
    input  logic [7:0] ip_di,
    input  logic       ip_do_rdy,
    output logic       err
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR_END,
        DATA_WR,
        DATA_RD,
        DATA_END
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] astb_sync, dstb_sync, wr_sync, valid_sync;
    logic [7:0]             db_sync [SYNC_STAGES];
    logic                   astb_s, dstb_s, wr_s, valid_s;
    logic [7:0]             db_s;
    logic                   armed;

    logic [7:0]    db_out, db_out_nxt;
    logic [7:0]    addr_nxt, do_nxt;
    logic          wr_nxt, rd_nxt, wait_nxt, err_nxt;
    logic [TW-1:0] timer, timer_nxt;

    assign astb_s  = astb_sync[SYNC_STAGES-1];
    assign dstb_s  = dstb_sync[SYNC_STAGES-1];
    assign wr_s    = wr_sync[SYNC_STAGES-1];
    assign valid_s = valid_sync[SYNC_STAGES-1];
    assign db_s    = db_sync[SYNC_STAGES-1];

    // Pads are driven only while the synchronised host view is a read strobe.
    assign Db_unsync = (wr_s && (!astb_s || !dstb_s)) ? db_out : 8'hzz;

    // Synchroniser chains; strobes idle high, valid marks when the chain holds real pad samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            astb_sync  <= '1;
            dstb_sync  <= '1;
            wr_sync    <= '1;
            valid_sync <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) db_sync[i] <= 8'h00;
        end else begin
            astb_sync  <= {astb_sync[SYNC_STAGES-2:0], Astb_unsync};
            dstb_sync  <= {dstb_sync[SYNC_STAGES-2:0], Dstb_unsync};
            wr_sync    <= {wr_sync[SYNC_STAGES-2:0], Wr_unsync};
            valid_sync <= {valid_sync[SYNC_STAGES-2:0], 1'b1};
            db_sync[0] <= Db_unsync;
            for (int i = 1; i < SYNC_STAGES; i++) db_sync[i] <= db_sync[i-1];
        end
    end

    // After reset a strobe still held from an aborted cycle must be released before it counts again.
    always_ff @(posedge clk) begin
        if (rst)                              armed <= 1'b0;
        else if (valid_s && astb_s && dstb_s) armed <= 1'b1;
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            Wait    <= 1'b0;
            ip_addr <= 8'h00;
            ip_do   <= 8'h00;
            ip_wr   <= 1'b0;
            ip_rd   <= 1'b0;
            err     <= 1'b0;
            db_out  <= 8'h00;
            timer   <= '0;
        end else begin
            state   <= state_nxt;
            Wait    <= wait_nxt;
            ip_addr <= addr_nxt;
            ip_do   <= do_nxt;
            ip_wr   <= wr_nxt;
            ip_rd   <= rd_nxt;
            err     <= err_nxt;
            db_out  <= db_out_nxt;
            timer   <= timer_nxt;
        end
    end

    // Next-state and next-output logic; bus pulses default low so they last one cycle.
    always_comb begin
        state_nxt  = state;
        wait_nxt   = Wait;
        addr_nxt   = ip_addr;
        do_nxt     = ip_do;
        wr_nxt     = 1'b0;
        rd_nxt     = 1'b0;
        err_nxt    = err;
        db_out_nxt = db_out;
        timer_nxt  = timer;

        case (state)
            IDLE: begin
                if (armed && !astb_s) begin
                    if (!wr_s) begin
                        addr_nxt = db_s;
                        err_nxt  = 1'b0;
                    end else begin
                        db_out_nxt = ip_addr;
                    end
                    state_nxt = ADDR_END;
                end else if (armed && !dstb_s) begin
                    timer_nxt = '0;
                    if (!wr_s) begin
                        do_nxt    = db_s;
                        wr_nxt    = 1'b1;
                        state_nxt = DATA_WR;
                    end else begin
                        rd_nxt    = 1'b1;
                        state_nxt = DATA_RD;
                    end
                end
            end

            DATA_WR, DATA_RD: begin
                if (ip_wr || ip_rd) begin
                    timer_nxt = timer;
                end else if (ip_do_rdy) begin
                    if (state == DATA_RD) db_out_nxt = ip_di;
                    if (AUTO_INC != 0) addr_nxt = ip_addr + 8'd1;
                    state_nxt = DATA_END;
                end else if (timer == TIMER_LAST) begin
                    err_nxt = 1'b1;
                    if (state == DATA_RD) db_out_nxt = ERR_DATA;
                    if (AUTO_INC != 0) addr_nxt = ip_addr + 8'd1;
                    state_nxt = DATA_END;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end

            DATA_END: begin
                if (!dstb_s) begin
                    wait_nxt = 1'b1;
                end else begin
                    wait_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end

            ADDR_END: begin
                if (!astb_s) begin
                    wait_nxt = 1'b1;
                end else begin
                    wait_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_epp_bridge.sv
// Directed bench for epp_bridge: host-side EPP cycles plus a simple register-bus responder.
module tb_epp_bridge;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       astb = 1'b1, dstb = 1'b1, wr = 1'b1;
    logic       host_drive = 1'b0;
    logic [7:0] host_data = 8'h00;
    logic [7:0] ip_di = 8'h00;
    logic       ip_do_rdy = 1'b0;
    wire  [7:0] db_bus, db_bus2;

    logic       wait_ack, ip_wr, ip_rd, err;
    logic [7:0] ip_addr, ip_do;
    logic       wait_ack2, ip_wr2, ip_rd2, err2;
    logic [7:0] ip_addr2, ip_do2;

    int vectors = 0;
    int miscompares = 0;

    logic       resp_en = 1'b1;
    logic       rdy_hold = 1'b0;
    int         resp_delay = 2;
    logic [7:0] resp_data = 8'h00;
    int         resp_cnt = 0;

    int         wr_pulses = 0, rd_pulses = 0;
    logic [7:0] last_ip_do = 8'h00;

    assign db_bus  = host_drive ? host_data : 8'hzz;
    assign db_bus2 = host_drive ? host_data : 8'hzz;

    always #5 clk = ~clk;

    epp_bridge #(.SYNC_STAGES(2), .AUTO_INC(1), .TIMEOUT(8), .ERR_DATA(8'hFF)) dut (
        .clk(clk), .rst(rst), .Db_unsync(db_bus), .Astb_unsync(astb), .Dstb_unsync(dstb),
        .Wr_unsync(wr), .Wait(wait_ack), .ip_addr(ip_addr), .ip_do(ip_do), .ip_wr(ip_wr),
        .ip_rd(ip_rd), .ip_di(ip_di), .ip_do_rdy(ip_do_rdy), .err(err)
    );

    epp_bridge #(.SYNC_STAGES(2), .AUTO_INC(0), .TIMEOUT(8), .ERR_DATA(8'hFF)) dut_static (
        .clk(clk), .rst(rst), .Db_unsync(db_bus2), .Astb_unsync(astb), .Dstb_unsync(dstb),
        .Wr_unsync(wr), .Wait(wait_ack2), .ip_addr(ip_addr2), .ip_do(ip_do2), .ip_wr(ip_wr2),
        .ip_rd(ip_rd2), .ip_di(ip_di), .ip_do_rdy(ip_do_rdy), .err(err2)
    );

    // Register-bus responder: answers a pulse after resp_delay cycles, or holds rdy high.
    always @(negedge clk) begin
        ip_do_rdy = rdy_hold;
        if (resp_cnt > 0) begin
            resp_cnt = resp_cnt - 1;
            if (resp_cnt == 0) begin
                ip_do_rdy = 1'b1;
                ip_di     = resp_data;
            end
        end else if ((ip_wr || ip_rd) && resp_en) begin
            resp_cnt = resp_delay;
        end
    end

    // Pulse monitor on the main instance.
    always @(negedge clk) begin
        if (ip_wr) begin
            wr_pulses  = wr_pulses + 1;
            last_ip_do = ip_do;
        end
        if (ip_rd) rd_pulses = rd_pulses + 1;
    end

    // Hang guard.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog observed=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors = vectors + 1;
        assert (observed === expected) else begin
            miscompares = miscompares + 1;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic wait_for_ack(input logic level, input string tag, output int cycles);
        cycles = 0;
        while (wait_ack !== level && cycles < 40) begin
            @(negedge clk);
            cycles = cycles + 1;
        end
        check_output(tag, {31'd0, wait_ack}, {31'd0, level});
    endtask

    task automatic host_addr_write(input logic [7:0] a);
        int c;
        host_data = a; host_drive = 1'b1; wr = 1'b0; astb = 1'b0;
        wait_for_ack(1'b1, "addr_wr_ack", c);
        astb = 1'b1;
        wait_for_ack(1'b0, "addr_wr_release", c);
        host_drive = 1'b0; wr = 1'b1;
        @(negedge clk);
    endtask

    task automatic host_data_write(input logic [7:0] d, output int rise, output int fall);
        host_data = d; host_drive = 1'b1; wr = 1'b0; dstb = 1'b0;
        wait_for_ack(1'b1, "data_wr_ack", rise);
        dstb = 1'b1;
        wait_for_ack(1'b0, "data_wr_release", fall);
        host_drive = 1'b0; wr = 1'b1;
        @(negedge clk);
    endtask

    task automatic host_data_read(output logic [7:0] d, output int rise);
        int c;
        host_drive = 1'b0; wr = 1'b1; dstb = 1'b0;
        wait_for_ack(1'b1, "data_rd_ack", rise);
        d = db_bus;
        dstb = 1'b1;
        wait_for_ack(1'b0, "data_rd_release", c);
        @(negedge clk);
    endtask

    function automatic logic bus_released(input logic [7:0] v);
        return $isunknown(v) || (v == 8'h00);
    endfunction

    initial begin
        logic [7:0] rd_val;
        int rise, fall, base;

        // Reset state
        repeat (3) @(negedge clk);
        check_output("reset_wait",  {31'd0, wait_ack}, 32'd0);
        check_output("reset_addr",  {24'd0, ip_addr}, 32'h00);
        check_output("reset_do",    {24'd0, ip_do}, 32'h00);
        check_output("reset_wr_rd", {30'd0, ip_wr, ip_rd}, 32'd0);
        check_output("reset_err",   {31'd0, err}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Address write then data write with a 2-cycle bus response
        $display("[TB] address write 3C, data write A5");
        host_addr_write(8'h3C);
        check_output("aw_addr", {24'd0, ip_addr}, 32'h3C);
        base = wr_pulses;
        host_data_write(8'hA5, rise, fall);
        check_output("dw_pulses", wr_pulses - base, 32'd1);
        check_output("dw_data",   {24'd0, last_ip_do}, 32'hA5);
        check_output("dw_fall",   fall, 32'd3);
        check_output("dw_inc",    {24'd0, ip_addr}, 32'h3D);
        check_output("dw_static", {24'd0, ip_addr2}, 32'h3C);

        // Block read across the address wrap
        $display("[TB] block read from FE");
        host_addr_write(8'hFE);
        check_output("br_addr0", {24'd0, ip_addr}, 32'hFE);
        base = rd_pulses;
        resp_data = 8'h11;
        host_data_read(rd_val, rise);
        check_output("br_data1", {24'd0, rd_val}, 32'h11);
        check_output("br_addr1", {24'd0, ip_addr}, 32'hFF);
        resp_data = 8'h22;
        host_data_read(rd_val, rise);
        check_output("br_data2", {24'd0, rd_val}, 32'h22);
        check_output("br_addr2", {24'd0, ip_addr}, 32'h00);
        resp_data = 8'h33;
        host_data_read(rd_val, rise);
        check_output("br_data3", {24'd0, rd_val}, 32'h33);
        check_output("br_addr3", {24'd0, ip_addr}, 32'h01);
        check_output("br_pulses", rd_pulses - base, 32'd3);

        // Timed-out read: 2 sync + 1 decode + 1 pulse + 8 wait + 1 ack = 13 cycles
        $display("[TB] read with no bus response");
        resp_en = 1'b0;
        base = rd_pulses;
        host_data_read(rd_val, rise);
        check_output("to_data",   {24'd0, rd_val}, 32'hFF);
        check_output("to_cycles", rise, 32'd13);
        check_output("to_err",    {31'd0, err}, 32'd1);
        check_output("to_addr",   {24'd0, ip_addr}, 32'h02);
        check_output("to_pulses", rd_pulses - base, 32'd1);
        resp_en = 1'b1;
        host_addr_write(8'h5A);
        check_output("to_err_clr", {31'd0, err}, 32'd0);

        // Address readback and bus release
        $display("[TB] address readback");
        wr = 1'b1; astb = 1'b0;
        wait_for_ack(1'b1, "ar_ack", rise);
        check_output("ar_data", {24'd0, db_bus}, 32'h5A);
        astb = 1'b1;
        wait_for_ack(1'b0, "ar_release", fall);
        check_output("ar_bus_z", {31'd0, bus_released(db_bus)}, 32'd1);
        @(negedge clk);

        // Reset during a held read strobe
        $display("[TB] reset during data read");
        resp_en = 1'b0;
        wr = 1'b1; dstb = 1'b0;
        rise = 0;
        while (ip_rd !== 1'b1 && rise < 20) begin
            @(negedge clk);
            rise = rise + 1;
        end
        check_output("rr_pulse_seen", {31'd0, ip_rd}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_output("rr_wait", {31'd0, wait_ack}, 32'd0);
        check_output("rr_rd",   {31'd0, ip_rd}, 32'd0);
        check_output("rr_addr", {24'd0, ip_addr}, 32'h00);
        check_output("rr_bus_z", {31'd0, bus_released(db_bus)}, 32'd1);
        base = rd_pulses;
        repeat (20) @(negedge clk);
        check_output("rr_no_pulse", rd_pulses - base, 32'd0);
        check_output("rr_no_wait",  {31'd0, wait_ack}, 32'd0);
        dstb = 1'b1;
        repeat (5) @(negedge clk);
        resp_en = 1'b1;
        resp_data = 8'h77;
        host_data_read(rd_val, rise);
        check_output("rr_redo_data",  {24'd0, rd_val}, 32'h77);
        check_output("rr_redo_pulse", rd_pulses - base, 32'd1);
        check_output("rr_redo_addr",  {24'd0, ip_addr}, 32'h01);

        // Bus ready held high: ignored during the pulse cycle
        $display("[TB] data write with ready held high");
        resp_en = 1'b0;
        rdy_hold = 1'b1;
        base = wr_pulses;
        host_data_write(8'hC3, rise, fall);
        check_output("rh_cycles", rise, 32'd6);
        check_output("rh_pulses", wr_pulses - base, 32'd1);
        check_output("rh_data",   {24'd0, last_ip_do}, 32'hC3);
        check_output("rh_addr",   {24'd0, ip_addr}, 32'h02);
        check_output("rh_static", {24'd0, ip_addr2}, 32'h00);
        rdy_hold = 1'b0;
        resp_en = 1'b1;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
